// File: rtl/c1541_sd_pkg.sv
// Shared state encoding, block geometry and address helper for the 1541 SD block responder.
package c1541_sd_pkg;

    localparam int BLK_BYTES = 512;
    localparam int BLK_SHIFT = 9;
    localparam int OFFS_W    = 14;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RD_REQ,
        RD_WAIT,
        BUF_WR,
        WR_ADDR,
        WR_LAT,
        WR_REQ,
        FINISH,
        RELEASE
    } state_t;

    // Callers truncate the result to their own memory address width.
    function automatic logic [31+BLK_SHIFT:0] blk_to_byte(input logic [31:0] lba);
        return {lba, {BLK_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/c1541_sd_addr_gen.sv
// Byte offset counter for a transfer, last-byte detect and image memory address sum.
module c1541_sd_addr_gen
    import c1541_sd_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [31:0]       lba_i,
    input  logic [4:0]        cnt_i,
    output logic [OFFS_W-1:0] offset_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] mem_addr_o
);

    logic [OFFS_W-1:0] offset_q, offset_d;
    logic [OFFS_W-1:0] last_off;

    always_comb begin
        offset_d = offset_q;
        if (clr_i) begin
            offset_d = '0;
        end else if (inc_i) begin
            offset_d = offset_q + OFFS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    // 32 blocks fill the 14-bit buffer exactly; the product wraps to 0 so the last offset is 0x3FFF.
    assign last_off   = OFFS_W'((OFFS_W'(cnt_i) + OFFS_W'(1)) * OFFS_W'(BLK_BYTES)) - OFFS_W'(1);
    assign last_o     = (offset_q == last_off);
    assign offset_o   = offset_q;
    assign mem_addr_o = ADDR_W'(BASE_ADDR) + ADDR_W'(blk_to_byte(lba_i)) + ADDR_W'(offset_q);

endmodule

// File: rtl/c1541_sd_responder.sv
// Block-device responder copying 512-byte blocks between the disk-image memory and the drive track buffer.
// IDLE wait request | CHECK range test | RD_REQ/RD_WAIT image read | BUF_WR buffer write | WR_ADDR/WR_LAT buffer read
// WR_REQ image write | FINISH drop ack, flag error | RELEASE wait for request levels to drop
module c1541_sd_responder
    import c1541_sd_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_BLOCKS = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic [5:0]        sd_blk_cnt,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic              sd_err,
    output logic [OFFS_W-1:0] sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready
);

    state_t      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wr_dir_q, wr_dir_d;
    logic        ack_q, ack_d;
    logic        err_flag_q, err_flag_d;
    logic        err_q, err_d;
    logic [7:0]  data_q, data_d;
    logic        clr, inc, last;
    logic [32:0] blk_end;

    c1541_sd_addr_gen #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (reset_n),
        .clr_i     (clr),
        .inc_i     (inc),
        .lba_i     (lba_q),
        .cnt_i     (cnt_q[4:0]),
        .offset_o  (sd_buff_addr),
        .last_o    (last),
        .mem_addr_o(mem_addr)
    );

    assign blk_end = {1'b0, lba_q} + 33'(cnt_q) + 33'd1;

    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        cnt_d      = cnt_q;
        wr_dir_d   = wr_dir_q;
        ack_d      = ack_q;
        err_flag_d = err_flag_q;
        err_d      = 1'b0;
        data_d     = data_q;
        clr        = 1'b0;
        inc        = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d    = sd_lba;
                    cnt_d    = sd_blk_cnt;
                    wr_dir_d = ~sd_rd;
                    ack_d    = 1'b1;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (blk_end > 33'(NUM_BLOCKS)) begin
                    err_flag_d = 1'b1;
                    state_d    = FINISH;
                end else begin
                    clr     = 1'b1;
                    state_d = wr_dir_q ? WR_ADDR : RD_REQ;
                end
            end
            // A ready already present in RD_REQ completes a single-cycle access.
            RD_REQ, RD_WAIT: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = BUF_WR;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            BUF_WR: begin
                sd_buff_wr = 1'b1;
                if (last) begin
                    state_d = FINISH;
                end else begin
                    inc     = 1'b1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: state_d = WR_LAT;
            WR_LAT: begin
                data_d  = sd_buff_din;
                state_d = WR_REQ;
            end
            WR_REQ: begin
                mem_wr = 1'b1;
                if (mem_ready) begin
                    if (last) begin
                        state_d = FINISH;
                    end else begin
                        inc     = 1'b1;
                        state_d = WR_ADDR;
                    end
                end
            end
            FINISH: begin
                ack_d      = 1'b0;
                err_d      = err_flag_q;
                err_flag_d = 1'b0;
                state_d    = RELEASE;
            end
            RELEASE: begin
                if (!sd_rd && !sd_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lba_q      <= '0;
            cnt_q      <= '0;
            wr_dir_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            lba_q      <= lba_d;
            cnt_q      <= cnt_d;
            wr_dir_q   <= wr_dir_d;
            ack_q      <= ack_d;
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    // One data register serves both directions; only one transfer runs at a time.
    assign sd_buff_dout = data_q;
    assign mem_wdata    = data_q;
    assign sd_ack       = ack_q;
    assign sd_err       = err_q;

endmodule

// File: tb/tb_c1541_sd_responder.sv
// Self-checking bench for c1541_sd_responder: request table plus scoreboard queues for memory and buffer traffic.
module tb_c1541_sd_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic [5:0]  sd_blk_cnt = '0;
    logic        sd_rd = 1'b0;
    logic        sd_wr = 1'b0;
    logic        sd_ack, sd_err, sd_buff_wr, mem_rd, mem_wr;
    logic [13:0] sd_buff_addr;
    logic [7:0]  sd_buff_dout, mem_wdata, mem_rdata;
    logic [7:0]  sd_buff_din = '0;
    logic [26:0] mem_addr;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    c1541_sd_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sd_lba      (sd_lba),
        .sd_blk_cnt  (sd_blk_cnt),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_err      (sd_err),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    // Image memory holds addr[7:0] at every byte; the track buffer holds ~addr[7:0] with one clock of latency.
    assign mem_rdata = mem_addr[7:0];
    always @(posedge clk) sd_buff_din <= ~sd_buff_addr[7:0];

    typedef struct {
        logic [26:0] maddr;
        logic [13:0] baddr;
        logic [7:0]  data;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic [5:0]  cnt;
        logic        stall;
        logic        exp_err;
        int          exp_ack_len;
    } vec_t;

    exp_t rdq[$];
    exp_t wrq[$];

    int checks = 0;
    int failures = 0;
    int wait_cnt = 0;
    bit stall_en = 1'b0;
    bit pend = 1'b0;
    logic [26:0] pend_addr = '0;
    logic [1:0]  pend_str = '0;
    logic prev_ack = 1'b0;
    int ack_run = 0, last_ack_len = 0;
    int ack_falls = 0, err_falls = 0, err_stray = 0;
    int rd_beats = 0, wr_beats = 0, buf_wrs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder, stall model and scoreboard pop side, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            pend      = 1'b0;
        end else begin
            if (pend) begin
                check("strobe_hold", {mem_rd, mem_wr}, pend_str);
                check("addr_hold", mem_addr, pend_addr);
            end
            mem_ready = 1'b0;
            if (mem_rd || mem_wr) begin
                if (wait_cnt == 0) mem_ready = 1'b1;
                else wait_cnt--;
            end
            pend      = (mem_rd || mem_wr) && !mem_ready;
            pend_addr = mem_addr;
            pend_str  = {mem_rd, mem_wr};
            if (mem_rd && mem_ready) begin
                rd_beats++;
                check("rd_beat_expected", rdq.size() != 0, 1);
                if (rdq.size() != 0) check("rd_mem_addr", mem_addr, rdq[0].maddr);
                wait_cnt = stall_en ? int'($urandom_range(0, 7)) : 0;
            end
            if (mem_wr && mem_ready) begin
                wr_beats++;
                check("wr_beat_expected", wrq.size() != 0, 1);
                if (wrq.size() != 0) begin
                    e = wrq.pop_front();
                    check("wr_mem_addr", mem_addr, e.maddr);
                    check("wr_mem_data", mem_wdata, e.data);
                end
                wait_cnt = stall_en ? int'($urandom_range(0, 7)) : 0;
            end
            if (sd_buff_wr) begin
                buf_wrs++;
                check("buf_wr_expected", rdq.size() != 0, 1);
                if (rdq.size() != 0) begin
                    e = rdq.pop_front();
                    check("buf_addr", sd_buff_addr, e.baddr);
                    check("buf_data", sd_buff_dout, e.data);
                end
            end
        end
        if (sd_ack) ack_run++;
        if (prev_ack && !sd_ack) begin
            ack_falls++;
            last_ack_len = ack_run;
            ack_run = 0;
            if (sd_err) err_falls++;
        end else if (sd_err) begin
            err_stray++;
        end
        prev_ack = sd_ack;
    end

    task automatic push_expected(input logic is_rd, input logic [31:0] lba, input int nbytes);
        exp_t e;
        for (int i = 0; i < nbytes; i++) begin
            e.baddr = 14'(i);
            e.maddr = 27'(lba * 32'd512 + 32'(i));
            e.data  = is_rd ? e.maddr[7:0] : ~e.baddr[7:0];
            if (is_rd) rdq.push_back(e);
            else wrq.push_back(e);
        end
    endtask

    task automatic run_req(input vec_t v, input string tag);
        int  nbytes, f0, e0, rb0, wb0, bw0;
        bit  stray;
        logic is_rd;
        is_rd  = v.rd;
        nbytes = v.exp_err ? 0 : (int'(v.cnt) + 1) * 512;
        push_expected(is_rd, v.lba, nbytes);
        f0 = ack_falls; e0 = err_falls; rb0 = rd_beats; wb0 = wr_beats; bw0 = buf_wrs;
        @(negedge clk);
        stall_en   = v.stall;
        sd_lba     = v.lba;
        sd_blk_cnt = v.cnt;
        sd_rd      = v.rd;
        sd_wr      = v.wr;
        for (int k = 0; k < 5 && !sd_ack; k++) @(negedge clk);
        check({tag, "/ack_rise"}, sd_ack, 1);
        sd_lba     = 32'hDEAD_BEEF;
        sd_blk_cnt = ~v.cnt;
        for (int k = 0; k < nbytes * 12 + 20 && sd_ack; k++) @(negedge clk);
        check({tag, "/ack_fall"}, sd_ack, 0);
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stray |= sd_ack;
        end
        check({tag, "/no_retrigger"}, stray, 0);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "/ack_falls"}, ack_falls - f0, 1);
        check({tag, "/err_pulse"}, err_falls - e0, v.exp_err);
        check({tag, "/rd_beats"}, rd_beats - rb0, is_rd ? nbytes : 0);
        check({tag, "/wr_beats"}, wr_beats - wb0, is_rd ? 0 : nbytes);
        check({tag, "/buf_wrs"}, buf_wrs - bw0, is_rd ? nbytes : 0);
        check({tag, "/rdq_drained"}, rdq.size(), 0);
        check({tag, "/wrq_drained"}, wrq.size(), 0);
        if (v.exp_ack_len != 0) check({tag, "/ack_len"}, last_ack_len, v.exp_ack_len);
        if (!is_rd && !v.exp_err) check({tag, "/buff_addr_end"}, sd_buff_addr, nbytes - 1);
    endtask

    vec_t vecs[8];

    initial begin
        int bw0;
        vecs[0] = '{1'b1, 1'b0, 32'd21,         6'd0,  1'b0, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b1, 32'd5,          6'h1F, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b0, 32'd1020,       6'd4,  1'b0, 1'b1, 2};
        vecs[3] = '{1'b1, 1'b0, 32'd21,         6'd0,  1'b1, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b1, 32'd3,          6'd0,  1'b0, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b1, 32'd1023,       6'd0,  1'b1, 1'b0, 0};
        vecs[6] = '{1'b0, 1'b1, 32'd1023,       6'd1,  1'b0, 1'b1, 2};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  6'h3F, 1'b0, 1'b1, 2};

        #3;
        check("reset_outputs_zero",
              {sd_ack, sd_err, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_wdata}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {sd_ack, sd_err, mem_rd, mem_wr, sd_buff_wr}, 0);

        for (int i = 0; i < 8; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // Abort a read at byte 300 with an asynchronous reset, then recover with a fresh read.
        push_expected(1'b1, 32'd21, 512);
        bw0 = buf_wrs;
        stall_en = 1'b0;
        @(negedge clk);
        sd_lba     = 32'd21;
        sd_blk_cnt = 6'd0;
        sd_rd      = 1'b1;
        for (int k = 0; k < 5000 && (buf_wrs - bw0) < 300; k++) @(negedge clk);
        check("abort_reached_byte300", (buf_wrs - bw0) >= 300, 1);
        #2 reset_n = 1'b0;
        #1 check("abort_outputs_zero",
                 {sd_ack, sd_err, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr, mem_wdata}, 0);
        sd_rd = 1'b0;
        rdq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_req('{1'b1, 1'b0, 32'd0, 6'd0, 1'b0, 1'b0, 0}, "post_reset");

        check("stray_err_pulses", err_stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
